// File: rtl/random_delay_gen_pkg.sv
// Shared types and defaults for the reaction timer delay and
// reaction-count blocks.
package random_delay_gen_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEF_TICK_DIV = 50000;
  localparam int DEF_MIN_MS   = 1000;
  localparam int DEF_RAND_W   = 12;

  // Bits needed to hold min_ms + 2^rand_w - 1
  function automatic int dly_width(
    input int min_ms,
    input int rand_w
  );
    return $clog2(min_ms + (1 << rand_w));
  endfunction

endpackage

// File: rtl/random_delay_gen_tick.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV enabled
// cycles, with a synchronous clear back to zero.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/random_delay_gen.sv
// Randomised pre-stimulus wait: latches MIN_MS + LFSR word on start,
// counts it down in ms ticks, then pulses go for one cycle.
module random_delay_gen
  import random_delay_gen_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int MIN_MS   = DEF_MIN_MS,
  parameter int RAND_W   = DEF_RAND_W,
  parameter int DLY_W    = dly_width(DEF_MIN_MS, DEF_RAND_W)
) (
  input  logic              clk50M,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [RAND_W-1:0] rand_in,
  output logic              busy,
  output logic              go,
  output logic [DLY_W-1:0]  delay_ms
);

  state_t           state;
  state_t           state_nx;
  logic [DLY_W-1:0] remaining;
  logic [DLY_W-1:0] new_dly;
  logic             tick;
  logic             accept;
  logic             last;

  assign new_dly = DLY_W'(MIN_MS) + DLY_W'(rand_in);
  assign accept  = (state == IDLE) && start && !abort;
  assign last    = (state == COUNT) && !abort && tick
                   && (remaining == DLY_W'(1));

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk50M),
    .rst_n(rst_n),
    .clr  (abort || (state != COUNT)),
    .en   (state == COUNT),
    .tick (tick)
  );

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start && !abort) state_nx = COUNT;
      COUNT: if (abort || last)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == COUNT);
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      delay_ms  <= '0;
      remaining <= '0;
      go        <= 1'b0;
    end else begin
      go <= last;
      if (accept) begin
        delay_ms  <= new_dly;
        remaining <= new_dly;
      end else if (state == COUNT) begin
        if (abort)     remaining <= '0;
        else if (tick) remaining <= remaining - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_random_delay_gen.sv
// Directed + randomised bench for random_delay_gen against an
// edge-level reference model of when a run ends.
module tb_random_delay_gen;

  localparam int T     = 4;
  localparam int MIN   = 2;
  localparam int RW    = 12;
  localparam int DW    = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [RW-1:0] rand_in;
  logic          busy;
  logic          go;
  logic [DW-1:0] delay_ms;

  int checks = 0;
  int errors = 0;

  random_delay_gen #(
    .TICK_DIV(T),
    .MIN_MS  (MIN),
    .RAND_W  (RW),
    .DLY_W   (DW)
  ) dut (
    .clk50M  (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .rand_in (rand_in),
    .busy    (busy),
    .go      (go),
    .delay_ms(delay_ms)
  );

  always #5 clk = ~clk;

  // Model: a run accepted at edge k ends at edge k + delay*T.
  int cyc;
  bit m_run;
  int m_dly;
  int m_end;
  int m_go_at;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc     <= 0;
      m_run   <= 1'b0;
      m_dly   <= 0;
      m_end   <= 0;
      m_go_at <= -1;
    end else begin
      cyc <= cyc + 1;
      if (m_run) begin
        if (abort) begin
          m_run <= 1'b0;
        end else if (cyc + 1 == m_end) begin
          m_run   <= 1'b0;
          m_go_at <= cyc + 1;
        end
      end else if (start && !abort) begin
        m_run <= 1'b1;
        m_dly <= MIN + int'(rand_in);
        m_end <= cyc + 1 + (MIN + int'(rand_in)) * T;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc_chk(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_busy"}, 32'(busy), 32'(m_run));
    chk({tag, "_go"}, 32'(go), 32'(m_go_at == cyc && cyc != 0));
    chk({tag, "_dly"}, 32'(delay_ms), 32'(m_dly));
  endtask

  task automatic run_delay(input logic [RW-1:0] r, input string tag);
    int bcnt;
    int gcyc;
    int gones;
    int exp_len;
    exp_len = (MIN + int'(r)) * T;
    rand_in = r;
    start = 1'b1;
    cyc_chk({tag, "_st"});
    chk({tag, "_latch"}, 32'(delay_ms), 32'(MIN + int'(r)));
    start = 1'b0;
    bcnt = int'(busy);
    gcyc = 0;
    gones = 0;
    for (int i = 1; i <= exp_len + 4; i++) begin
      rand_in = RW'($urandom);
      cyc_chk(tag);
      if (busy) bcnt++;
      if (go) begin
        gones++;
        if (gcyc == 0) gcyc = i;
      end
    end
    chk({tag, "_busy_len"}, 32'(bcnt), 32'(exp_len));
    chk({tag, "_go_cyc"}, 32'(gcyc), 32'(exp_len));
    chk({tag, "_go_cnt"}, 32'(gones), 32'd1);
  endtask

  initial begin
    int gcyc;
    int gones;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    rand_in = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_dly", 32'(delay_ms), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc_chk("idle");

    run_delay(12'd3, "r3");
    run_delay(12'd0, "r0");
    run_delay(12'd4095, "rmax");
    chk("rmax_nowrap", 32'(delay_ms), 32'd4097);
    for (int n = 0; n < 3; n++)
      run_delay(RW'($urandom_range(0, 20)), "rnd");

    // abort after 10 cycles of counting
    rand_in = 12'd3;
    start = 1'b1;
    cyc_chk("ab_st");
    start = 1'b0;
    repeat (9) cyc_chk("ab_run");
    abort = 1'b1;
    cyc_chk("ab_edge");
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_hold", 32'(delay_ms), 32'd5);
    gones = 0;
    for (int i = 0; i < 30; i++) begin
      cyc_chk("ab_quiet");
      if (go) gones++;
    end
    chk("ab_nogo", 32'(gones), 32'd0);
    run_delay(RW'($urandom_range(0, 10)), "ab_again");

    // abort on the final tick edge
    rand_in = 12'd0;
    start = 1'b1;
    cyc_chk("abl_st");
    start = 1'b0;
    repeat (MIN * T - 1) cyc_chk("abl_run");
    abort = 1'b1;
    cyc_chk("abl_edge");
    abort = 1'b0;
    chk("abl_nogo", 32'(go), 32'd0);
    repeat (3) cyc_chk("abl_after");

    // start noise and rand_in churn during count, then back-to-back
    rand_in = 12'd3;
    start = 1'b1;
    cyc_chk("bb_st");
    gcyc = 0;
    for (int i = 1; i <= 15; i++) begin
      start = 1'($urandom);
      rand_in = RW'($urandom);
      cyc_chk("bb_noise");
    end
    start = 1'b1;
    rand_in = 12'd7;
    for (int i = 16; i <= 25 && gcyc == 0; i++) begin
      cyc_chk("bb_wait");
      if (go) gcyc = i;
    end
    chk("bb_go_cyc", 32'(gcyc), 32'd20);
    cyc_chk("bb_restart");
    start = 1'b0;
    chk("bb_busy", 32'(busy), 32'd1);
    chk("bb_dly", 32'(delay_ms), 32'd9);
    repeat (9 * T + 3) cyc_chk("bb_run2");

    // asynchronous reset mid-count
    rand_in = 12'd5;
    start = 1'b1;
    cyc_chk("ar_st");
    start = 1'b0;
    repeat (10) cyc_chk("ar_run");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_go", 32'(go), 32'd0);
    chk("ar_dly", 32'(delay_ms), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gones = 0;
    for (int i = 0; i < 40; i++) begin
      cyc_chk("ar_quiet");
      if (go || busy) gones++;
    end
    chk("ar_nogo", 32'(gones), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
